// File: rtl/data_sram_responder.sv
// Data-port SRAM responder: word-addressed array plus an in-order queue of
// accepted requests, each answered by one data_ok pulse after LATENCY edges.
module data_sram_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  pending_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [2:0]    LAT  = 3'(LATENCY);
  localparam logic [3:0]    MAXQ = 4'(OUTSTANDING);
  localparam logic [PW-1:0] LAST = PW'(OUTSTANDING - 1);

  logic [31:0]       mem_q [DEPTH];

  logic              is_load_q [OUTSTANDING];
  logic              is_load_d [OUTSTANDING];
  logic [31:0]       rdat_q    [OUTSTANDING];
  logic [31:0]       rdat_d    [OUTSTANDING];
  logic [2:0]        age_q     [OUTSTANDING];
  logic [2:0]        age_d     [OUTSTANDING];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              retire;
  logic              unused_addr_bits;

  assign idx              = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Acceptance is gated by resetn so addr_ok reads 0 for the whole reset window;
  // no retire bypass: a full queue refuses even while its head is answering.
  assign data_sram_addr_ok = resetn & (cnt_q < MAXQ);
  assign data_sram_data_ok = (cnt_q != 4'd0) && (age_q[head_q] == LAT);
  assign data_sram_rdata   = (data_sram_data_ok && is_load_q[head_q]) ? rdat_q[head_q] : '0;
  assign pending_cnt       = cnt_q;

  assign accept = data_sram_en & data_sram_addr_ok;
  assign retire = data_sram_data_ok;

  // Store commit: byte lanes selected by we, array itself has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_we[b]) begin
          mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue next state: age all entries, enqueue at tail, dequeue at head.
  always_comb begin
    is_load_d = is_load_q;
    rdat_d    = rdat_q;
    age_d     = age_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;

    for (int unsigned i = 0; i < OUTSTANDING; i++) begin
      if (age_q[i] != LAT) begin
        age_d[i] = age_q[i] + 3'd1;
      end
    end

    if (accept) begin
      is_load_d[tail_q] = (data_sram_we == 4'h0);
      rdat_d[tail_q]    = mem_q[idx];
      age_d[tail_q]     = 3'd1;
      tail_d            = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end

    if (retire) begin
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end

    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state register; reset drops every outstanding request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        is_load_q[i] <= 1'b0;
        rdat_q[i]    <= '0;
        age_q[i]     <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      is_load_q <= is_load_d;
      rdat_q    <= rdat_d;
      age_q     <= age_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: three responders share one request bus (LATENCY 2, 1 and 5);
// each scenario checks only the instance it targets.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        a_ok, a_dok, b_ok, b_dok, c_ok, c_dok;
  logic [31:0] a_rd, b_rd, c_rd;
  logic [3:0]  a_pend, b_pend, c_pend;

  int n_vec = 0;
  int n_err = 0;

  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .OUTSTANDING(4)) u_a (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_addr_ok(a_ok),
    .data_sram_data_ok(a_dok), .data_sram_rdata(a_rd), .pending_cnt(a_pend));

  data_sram_responder #(.ADDR_W(10), .LATENCY(1), .OUTSTANDING(4)) u_b (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_addr_ok(b_ok),
    .data_sram_data_ok(b_dok), .data_sram_rdata(b_rd), .pending_cnt(b_pend));

  data_sram_responder #(.ADDR_W(10), .LATENCY(5), .OUTSTANDING(4)) u_c (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_addr_ok(c_ok),
    .data_sram_data_ok(c_dok), .data_sram_rdata(c_rd), .pending_cnt(c_pend));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] ad,
                       input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = ad;
    wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [3:0] pend_of(input int sel);
    case (sel)
      0:       return a_pend;
      1:       return b_pend;
      default: return c_pend;
    endcase
  endfunction

  task automatic wait_idle(input int sel, input string tag);
    int n = 0;
    idle();
    while (pend_of(sel) != 4'd0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(pend_of(sel)), 32'd0);
  endtask

  logic [31:0] model [int];
  logic [31:0] expq [$];

  initial begin
    int req;
    int got;
    logic acc;
    logic [31:0] ra;
    logic [31:0] rd;
    logic st;

    resetn = 1'b0;
    idle();
    tick();
    tick();
    check("rst_addr_ok", 32'(a_ok), 32'd0);
    check("rst_data_ok", 32'(a_dok), 32'd0);
    check("rst_rdata", a_rd, 32'h0);
    check("rst_pend", 32'(a_pend), 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_addr_ok", 32'(a_ok), 32'd1);

    // store then load through the same word
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    tick();
    check("t1_pend1", 32'(a_pend), 32'd1);
    check("t1_nodok", 32'(a_dok), 32'd0);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    tick();
    check("t1_st_dok", 32'(a_dok), 32'd1);
    check("t1_st_rdata", a_rd, 32'h0);
    check("t1_pend2", 32'(a_pend), 32'd2);
    idle();
    tick();
    check("t1_ld_dok", 32'(a_dok), 32'd1);
    check("t1_ld_rdata", a_rd, 32'hDEADBEEF);
    check("t1_pend1b", 32'(a_pend), 32'd1);
    tick();
    check("t1_end_dok", 32'(a_dok), 32'd0);
    check("t1_end_pend", 32'(a_pend), 32'd0);

    // byte strobe merges one lane
    drive(1'b1, 4'hF, 32'h20, 32'h11223344);
    tick();
    drive(1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA);
    tick();
    check("t2_s1_dok", 32'(a_dok), 32'd1);
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    tick();
    check("t2_s2_rdata", a_rd, 32'h0);
    idle();
    tick();
    check("t2_ld_dok", 32'(a_dok), 32'd1);
    check("t2_ld_rdata", a_rd, 32'h11AA3344);
    tick();
    check("t2_end_pend", 32'(a_pend), 32'd0);

    // LATENCY=1 instance
    wait_idle(1, "b_idle");
    drive(1'b1, 4'hF, 32'h4, 32'h0BADF00D);
    tick();
    check("l1_st_dok", 32'(b_dok), 32'd1);
    check("l1_st_rdata", b_rd, 32'h0);
    check("l1_st_pend", 32'(b_pend), 32'd1);
    idle();
    tick();
    check("l1_st_done", 32'(b_pend), 32'd0);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    tick();
    check("l1_ld_dok", 32'(b_dok), 32'd1);
    check("l1_ld_rdata", b_rd, 32'h0BADF00D);
    check("l1_ld_pend", 32'(b_pend), 32'd1);
    idle();
    tick();
    check("l1_ld_nodok", 32'(b_dok), 32'd0);
    check("l1_ld_pend0", 32'(b_pend), 32'd0);

    // ten mixed requests with en held high
    wait_idle(0, "a_idle");
    req = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      acc = 1'b0;
      if (req < 10) begin
        st = (req % 2) == 0;
        ra = 32'h40 + 32'(4 * ((req / 2) % 3));
        rd = 32'h10000000 + 32'(req);
        drive(1'b1, st ? 4'hF : 4'h0, ra, rd);
        if (a_ok) begin
          acc = 1'b1;
          if (st) begin
            expq.push_back(32'h0);
            model[ra] = rd;
          end else begin
            expq.push_back(model[ra]);
          end
        end
      end else begin
        idle();
      end
      tick();
      if (acc) req++;
      if (a_dok) begin
        if (expq.size() == 0) begin
          check("wrap_extra_dok", 32'(a_dok), 32'd0);
        end else begin
          check("wrap_rdata", a_rd, expq.pop_front());
        end
        got++;
      end
      check("wrap_pend_le4", 32'(a_pend <= 4'd4), 32'd1);
    end
    idle();
    check("wrap_count", 32'(got), 32'd10);
    tick();
    check("wrap_pend0", 32'(a_pend), 32'd0);

    // LATENCY=5 instance: fill the queue, then back-to-back loads
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF, 32'(4 * i), 32'hC0DE0000 + 32'(i));
      tick();
      check("c_pre_pend", 32'(c_pend), 32'(i + 1));
    end
    check("c_pre_full", 32'(c_ok), 32'd0);
    wait_idle(2, "c_pre_idle");

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 32'(4 * i), 32'h0);
      tick();
      check("bb_pend", 32'(c_pend), 32'(i + 1));
    end
    check("bb_full_ok", 32'(c_ok), 32'd0);
    check("bb_full_dok", 32'(c_dok), 32'd0);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    tick();
    check("bb_r0_dok", 32'(c_dok), 32'd1);
    check("bb_r0_rdata", c_rd, 32'hC0DE0000);
    check("bb_r0_nobypass", 32'(c_ok), 32'd0);
    check("bb_r0_pend", 32'(c_pend), 32'd4);
    tick();
    check("bb_r1_rdata", c_rd, 32'hC0DE0001);
    check("bb_r1_ok", 32'(c_ok), 32'd1);
    check("bb_r1_pend", 32'(c_pend), 32'd3);
    tick();
    idle();
    check("bb_r2_rdata", c_rd, 32'hC0DE0002);
    check("bb_r2_pend", 32'(c_pend), 32'd3);
    tick();
    check("bb_r3_dok", 32'(c_dok), 32'd1);
    check("bb_r3_rdata", c_rd, 32'hC0DE0003);
    check("bb_r3_pend", 32'(c_pend), 32'd2);
    tick();
    check("bb_gap1", 32'(c_dok), 32'd0);
    tick();
    check("bb_gap2", 32'(c_dok), 32'd0);
    tick();
    check("bb_r4_dok", 32'(c_dok), 32'd1);
    check("bb_r4_rdata", c_rd, 32'hC0DE0000);
    tick();
    check("bb_end_pend", 32'(c_pend), 32'd0);

    // asynchronous reset with three requests in flight
    drive(1'b1, 4'hF, 32'h80, 32'h5A5A5A5A);
    tick();
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    tick();
    idle();
    check("mr_pend3", 32'(c_pend), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("mr_addr_ok", 32'(c_ok), 32'd0);
    check("mr_data_ok", 32'(c_dok), 32'd0);
    check("mr_rdata", c_rd, 32'h0);
    check("mr_pend", 32'(c_pend), 32'd0);
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mr_no_stale", 32'(c_dok), 32'd0);
    end
    drive(1'b1, 4'h0, 32'h80, 32'h0);
    tick();
    check("mr_ld_pend", 32'(c_pend), 32'd1);
    idle();
    for (int i = 0; i < 3; i++) tick();
    check("mr_ld_early", 32'(c_dok), 32'd0);
    tick();
    check("mr_ld_dok", 32'(c_dok), 32'd1);
    check("mr_ld_rdata", c_rd, 32'h5A5A5A5A);
    tick();
    check("mr_end_pend", 32'(c_pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data port that the MEM stage drives.
- Accepts requests (en, byte-strobe we, addr, wdata) with an addr_ok handshake and returns in-order single-cycle data_ok pulses with rdata after a fixed latency.
- Holds a word-addressed data array and an in-order outstanding-request queue.
- Serves as the data RAM model in simulation and as the timing reference for MEM-stage stall logic.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words.
- LATENCY, 2, rising edges from acceptance edge to data_ok assertion; legal range 1..7.
- OUTSTANDING, 4, maximum accepted-but-unanswered requests; legal range 1..8.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_en  in  1  request valid.
- data_sram_we  in  4  byte write strobes; nonzero = store, zero = load.
- data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2].
- data_sram_wdata  in  32  store data, already lane-replicated by requester.
- data_sram_addr_ok  out  1  request accepted this cycle if en also high.
- data_sram_data_ok  out  1  one-cycle response pulse.
- data_sram_rdata  out  32  load data, valid only while data_ok=1.
- pending_cnt  out  4  number of outstanding requests, for verification.

Behaviour:
- Reset: asynchronous active-low reset on one clock clk, resetn.
  - While resetn=0: addr_ok=0, data_ok=0, rdata=0, pending_cnt=0, queue emptied.
  - Array contents are not reset.
  - Reset asserted mid-operation drops all outstanding requests; no data_ok is produced for them.
  - Stores already committed remain in the array.
- Handshake:
  - addr_ok = (pending_cnt < OUTSTANDING), registered-state only, independent of en.
  - Acceptance edge = rising edge with en=1 and addr_ok=1.
  - Requester holds en/we/addr/wdata until acceptance.
  - At most one acceptance per edge.
- No full bypass: when pending_cnt==OUTSTANDING, addr_ok=0 even in a cycle where data_ok retires an entry; acceptance resumes next cycle.
- Store commit: on the acceptance edge, byte lane i of array[idx] takes wdata[8i+7:8i] where we[i]=1; other lanes are unchanged.
- Load sampling: on the acceptance edge, array[idx] is captured into the queue entry, using contents before this edge.
  - A load accepted on a later edge than a store sees the store.
  - Full 32-bit word is returned; lane selection and sign extension belong to the requester.
- Queue entry fields: {is_load, rdata, age}.
  - age starts at 1 on the acceptance edge and increments each edge, saturating at LATENCY.
- Response:
  - data_ok=1 in the cycle where the head entry has age==LATENCY.
  - In that cycle, rdata = head rdata for loads and 32'h0 for stores.
  - The head retires on the following edge.
  - Both loads and stores get exactly one data_ok.
  - No backpressure: requester must accept the pulse.
- Timing: for request accepted at edge k, data_ok is high during the cycle after edge k+LATENCY-1.
  - LATENCY=1 means data_ok in the cycle immediately after acceptance.
- Ordering: responses are strictly in acceptance order.
  - Back-to-back acceptances give back-to-back data_ok pulses in consecutive cycles.
- pending_cnt arithmetic:
  - +1 on acceptance, -1 on retire.
  - Simultaneous accept and retire leaves it unchanged.
  - Never exceeds OUTSTANDING, never underflows.
- Queue storage is circular with head/tail pointers mod OUTSTANDING; pointer wrap must be seamless.
- Address: bits above ADDR_W+1 are ignored (aliasing); addr[1:0] is ignored by the array; no alignment check.
- Outputs are registered or decoded from registered state only; no combinational path from en/addr to addr_ok/data_ok.

Test Plan:
- Reset then store: write we=4'hF, addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 (LATENCY=2) -> load data_ok 2 edges after its acceptance, rdata=0xDEADBEEF; store data_ok rdata=0.
- Byte strobe: preload 0x11223344 at 0x20, store we=4'b0100 wdata=0xAAAAAAAA, then load 0x20 -> rdata=0x11AA3344.
- Back-to-back: 4 loads accepted on consecutive edges (OUTSTANDING=4) -> addr_ok drops with pending_cnt=4.
  - data_ok pulses on 4 consecutive cycles in order.
  - addr_ok returns high the cycle after the first retire, not during it.
- Wrap-around: 10 consecutive load/store mixes with en held high -> every request gets exactly one data_ok in order; pending_cnt never exceeds 4 and ends at 0.
- LATENCY=1 single load at addr 0x4 -> data_ok high the cycle immediately after acceptance, pending_cnt 1->0.
- Reset mid-flight: 3 requests outstanding, pulse resetn low asynchronously between edges.
  - Outputs go 0 immediately, pending_cnt=0, no stale data_ok after release.
  - A store committed before reset is still readable afterwards.
